// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types for the bank command arbiter: command classes, FSM states,
// default DRAM timing values and helpers used by the arbiter and its picker.
// Ports: none (package).
package bank_cmd_arbiter_pkg;

  localparam int DEF_NBANKS = 8;
  localparam int DEF_ABITS  = 14;
  localparam int DEF_TCCD   = 2;
  localparam int DEF_TRRD   = 4;
  localparam int DEF_TWTR   = 6;
  localparam int DEF_TRTW   = 4;
  localparam int DEF_TRFC   = 32;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_READ,
    CMD_WRITE,
    CMD_ACT,
    CMD_PRE,
    CMD_REF
  } cmd_cls_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REF_WAIT,
    ST_REF_ISSUE,
    ST_REF_HOLD
  } arb_state_e;

  // READ wins over WRITE if a bank ever raises both CAS type bits.
  function automatic cmd_cls_e classify(input logic cas, input logic ras, input logic we,
                                        input logic is_read, input logic is_write);
    cmd_cls_e c;
    c = CMD_NOP;
    if (cas && is_read)             c = CMD_READ;
    else if (cas && is_write)       c = CMD_WRITE;
    else if (ras && !cas && !we)    c = CMD_ACT;
    else if (ras && !cas && we)     c = CMD_PRE;
    return c;
  endfunction

  // One extra bit over the largest timing value so a load never wraps.
  function automatic int cnt_width(input int a, input int b, input int c, input int d,
                                   input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/bank_cmd_arbiter_rr_picker.sv
// Round-robin picker: first set bit of elig_i at or above ptr_i, wrapping.
// Latency: combinational. Backpressure: none, pure select logic.
// Ports: elig_i (eligible vector), ptr_i (start index) -> gnt_o (one-hot),
//        idx_o (grant index), any_o (a grant exists).
module bank_cmd_arbiter_rr_picker #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && elig_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Shares the DRAM command slot between NBANKS bank machines, round-robin,
// enforcing tCCD/tRRD/tWTR/tRTW and sequencing all-bank refresh (REF, tRFC hold).
// Latency: bm_ready same cycle as grant, phy_* one cycle later. Backpressure:
// a bank waits (bm_ready=0) while its timing class is blocked or refresh runs.
// Ports: sys_clk/sys_rst; bm_* per-bank command streams in, bm_ready out;
//        ref_req/ref_done refresher handshake; bm_refresh_req/bm_refresh_gnt to
//        bank machines; phy_valid/phy_a/phy_ba/phy_cas/phy_ras/phy_we registered out.
module bank_cmd_arbiter
  import bank_cmd_arbiter_pkg::*;
#(
  parameter int NBANKS = DEF_NBANKS,
  parameter int ABITS  = DEF_ABITS,
  parameter int TCCD   = DEF_TCCD,
  parameter int TRRD   = DEF_TRRD,
  parameter int TWTR   = DEF_TWTR,
  parameter int TRTW   = DEF_TRTW,
  parameter int TRFC   = DEF_TRFC,
  parameter int BAW    = $clog2(NBANKS)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NBANKS-1:0]       bm_valid,
  output logic [NBANKS-1:0]       bm_ready,
  input  logic [NBANKS*ABITS-1:0] bm_a,
  input  logic [NBANKS-1:0]       bm_cas,
  input  logic [NBANKS-1:0]       bm_ras,
  input  logic [NBANKS-1:0]       bm_we,
  input  logic [NBANKS-1:0]       bm_is_read,
  input  logic [NBANKS-1:0]       bm_is_write,
  input  logic                    ref_req,
  output logic                    ref_done,
  output logic                    bm_refresh_req,
  input  logic [NBANKS-1:0]       bm_refresh_gnt,
  output logic                    phy_valid,
  output logic [ABITS-1:0]        phy_a,
  output logic [BAW-1:0]          phy_ba,
  output logic                    phy_cas,
  output logic                    phy_ras,
  output logic                    phy_we
);

  localparam int CW = cnt_width(TCCD, TRRD, TWTR, TRTW, TRFC);

  arb_state_e       state_q, state_d;
  logic [BAW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    ccd_q, ccd_d, rrd_q, rrd_d, wtr_q, wtr_d, rtw_q, rtw_d, rfc_q, rfc_d;

  logic             phy_valid_q, phy_valid_d;
  logic [ABITS-1:0] phy_a_q, phy_a_d;
  logic [BAW-1:0]   phy_ba_q, phy_ba_d;
  logic             phy_cas_q, phy_cas_d, phy_ras_q, phy_ras_d, phy_we_q, phy_we_d;

  logic [NBANKS-1:0] elig;
  logic [NBANKS-1:0] gnt;
  logic [BAW-1:0]    gidx;
  logic              gany;
  logic              run_en;
  cmd_cls_e          g_cls;

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Reset gates grants combinationally so bm_ready drops the instant it asserts.
  assign run_en = (state_q == ST_RUN) && !sys_rst;

  always_comb begin
    elig = '0;
    for (int b = 0; b < NBANKS; b++) begin
      unique case (classify(bm_cas[b], bm_ras[b], bm_we[b], bm_is_read[b], bm_is_write[b]))
        CMD_READ:  elig[b] = bm_valid[b] && (ccd_q == '0) && (wtr_q == '0);
        CMD_WRITE: elig[b] = bm_valid[b] && (ccd_q == '0) && (rtw_q == '0);
        CMD_ACT:   elig[b] = bm_valid[b] && (rrd_q == '0);
        CMD_PRE:   elig[b] = bm_valid[b];
        default:   elig[b] = 1'b0;
      endcase
    end
    if (!run_en) elig = '0;
  end

  bank_cmd_arbiter_rr_picker #(
    .N  (NBANKS),
    .IW (BAW)
  ) u_picker (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .any_o  (gany)
  );

  assign bm_ready = gnt;
  assign g_cls    = classify(bm_cas[gidx], bm_ras[gidx], bm_we[gidx],
                             bm_is_read[gidx], bm_is_write[gidx]);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    ccd_d          = dec(ccd_q);
    rrd_d          = dec(rrd_q);
    wtr_d          = dec(wtr_q);
    rtw_d          = dec(rtw_q);
    rfc_d          = dec(rfc_q);
    phy_valid_d    = 1'b0;
    phy_a_d        = '0;
    phy_ba_d       = '0;
    phy_cas_d      = 1'b0;
    phy_ras_d      = 1'b0;
    phy_we_d       = 1'b0;
    ref_done       = 1'b0;
    bm_refresh_req = (state_q != ST_RUN);

    if (gany) begin
      ptr_d       = (int'(gidx) == NBANKS - 1) ? '0 : gidx + 1'b1;
      phy_valid_d = 1'b1;
      phy_a_d     = bm_a[gidx*ABITS +: ABITS];
      phy_ba_d    = gidx;
      phy_cas_d   = bm_cas[gidx];
      phy_ras_d   = bm_ras[gidx];
      phy_we_d    = bm_we[gidx];
      unique case (g_cls)
        CMD_READ: begin
          ccd_d = CW'(TCCD - 1);
          rtw_d = CW'(TRTW - 1);
        end
        CMD_WRITE: begin
          ccd_d = CW'(TCCD - 1);
          wtr_d = CW'(TWTR - 1);
        end
        CMD_ACT: rrd_d = CW'(TRRD - 1);
        default: ;
      endcase
    end

    unique case (state_q)
      ST_RUN: begin
        if (ref_req) state_d = ST_REF_WAIT;
      end
      ST_REF_WAIT: begin
        if (&bm_refresh_gnt) state_d = ST_REF_ISSUE;
      end
      ST_REF_ISSUE: begin
        phy_valid_d = 1'b1;
        phy_cas_d   = 1'b1;
        phy_ras_d   = 1'b1;
        rfc_d       = CW'(TRFC - 1);
        state_d     = ST_REF_HOLD;
      end
      ST_REF_HOLD: begin
        if (rfc_q == '0) begin
          ref_done = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_RUN;
      ptr_q       <= '0;
      ccd_q       <= '0;
      rrd_q       <= '0;
      wtr_q       <= '0;
      rtw_q       <= '0;
      rfc_q       <= '0;
      phy_valid_q <= 1'b0;
      phy_a_q     <= '0;
      phy_ba_q    <= '0;
      phy_cas_q   <= 1'b0;
      phy_ras_q   <= 1'b0;
      phy_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ccd_q       <= ccd_d;
      rrd_q       <= rrd_d;
      wtr_q       <= wtr_d;
      rtw_q       <= rtw_d;
      rfc_q       <= rfc_d;
      phy_valid_q <= phy_valid_d;
      phy_a_q     <= phy_a_d;
      phy_ba_q    <= phy_ba_d;
      phy_cas_q   <= phy_cas_d;
      phy_ras_q   <= phy_ras_d;
      phy_we_q    <= phy_we_d;
    end
  end

  assign phy_valid = phy_valid_q;
  assign phy_a     = phy_a_q;
  assign phy_ba    = phy_ba_q;
  assign phy_cas   = phy_cas_q;
  assign phy_ras   = phy_ras_q;
  assign phy_we    = phy_we_q;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: expected phy commands (cycle, bank, bits) are
// queued as stimulus is applied and compared as phy_valid strobes.
module tb_bank_cmd_arbiter;

  localparam int NB = 8;
  localparam int AB = 14;
  localparam int C_RD = 0, C_WR = 1, C_ACT = 2, C_PRE = 3, C_REF = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [NB-1:0]    bm_valid, bm_ready, bm_cas, bm_ras, bm_we, bm_is_read, bm_is_write;
  logic [NB*AB-1:0] bm_a;
  logic             ref_req, ref_done, bm_refresh_req;
  logic [NB-1:0]    bm_refresh_gnt;
  logic             phy_valid, phy_cas, phy_ras, phy_we;
  logic [AB-1:0]    phy_a;
  logic [2:0]       phy_ba;

  bank_cmd_arbiter dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .bm_valid(bm_valid), .bm_ready(bm_ready), .bm_a(bm_a),
    .bm_cas(bm_cas), .bm_ras(bm_ras), .bm_we(bm_we),
    .bm_is_read(bm_is_read), .bm_is_write(bm_is_write),
    .ref_req(ref_req), .ref_done(ref_done),
    .bm_refresh_req(bm_refresh_req), .bm_refresh_gnt(bm_refresh_gnt),
    .phy_valid(phy_valid), .phy_a(phy_a), .phy_ba(phy_ba),
    .phy_cas(phy_cas), .phy_ras(phy_ras), .phy_we(phy_we)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    int         ba;
    logic [AB-1:0] a;
    logic [2:0] crw;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0, n_pass = 0;
  int            cyc = 0;
  int            aseed = 1;
  int            exp_done = -1;
  logic          done_seen = 1'b0;
  logic          hold_vld = 1'b0;
  logic [NB-1:0] rdy_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // {cas, ras, we, is_read, is_write}
  function automatic logic [4:0] bits_of(input int c);
    case (c)
      C_RD:    return 5'b10010;
      C_WR:    return 5'b10101;
      C_ACT:   return 5'b01000;
      C_PRE:   return 5'b01100;
      default: return 5'b11000;
    endcase
  endfunction

  function automatic logic [AB-1:0] a_of(input int b);
    return AB'(aseed * 64 + b * 5 + 3);
  endfunction

  task automatic load(input int b, input int c);
    logic [4:0] bb;
    bb = bits_of(c);
    bm_cas[b]      = bb[4];
    bm_ras[b]      = bb[3];
    bm_we[b]       = bb[2];
    bm_is_read[b]  = bb[1];
    bm_is_write[b] = bb[0];
    bm_a[b*AB +: AB] = a_of(b);
    bm_valid[b]    = 1'b1;
  endtask

  task automatic exp_push(input int c, input int b, input int cmd);
    exp_t e;
    logic [4:0] bb;
    bb    = bits_of(cmd);
    e.cyc = c;
    e.ba  = (cmd == C_REF) ? 0 : b;
    e.a   = (cmd == C_REF) ? '0 : a_of(b);
    e.crw = bb[4:2];
    sb.push_back(e);
  endtask

  // One clock: monitor at negedge, then advance and retire accepted commands.
  task automatic step();
    exp_t e;
    @(negedge sys_clk);
    rdy_s = bm_ready;
    if (phy_valid) begin
      if (sb.size() == 0) chk("phy_spurious", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("phy_cyc", 32'(cyc), 32'(e.cyc));
        chk("phy_ba", 32'(phy_ba), 32'(e.ba));
        chk("phy_cmd", 32'({phy_a, phy_cas, phy_ras, phy_we}), 32'({e.a, e.crw}));
      end
    end
    if (ref_done) begin
      done_seen = 1'b1;
      chk("ref_done_cyc", 32'(cyc), 32'(exp_done));
    end
    @(posedge sys_clk);
    cyc++;
    #1;
    if (!hold_vld) bm_valid = bm_valid & ~rdy_s;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int t, s, r, L, q, u;
    sys_rst = 1'b1;
    bm_valid = '0; bm_cas = '0; bm_ras = '0; bm_we = '0;
    bm_is_read = '0; bm_is_write = '0; bm_a = '0;
    ref_req = 1'b0; bm_refresh_gnt = '0;

    // Reset state: everything quiet even with a request presented.
    idle(2);
    load(0, C_RD);
    #1;
    chk("rst_ready", 32'(bm_ready), 32'd0);
    chk("rst_phy_valid", 32'(phy_valid), 32'd0);
    chk("rst_phy_bits", 32'({phy_a, phy_ba, phy_cas, phy_ras, phy_we}), 32'd0);
    chk("rst_refresh_req", 32'(bm_refresh_req), 32'd0);
    chk("rst_ref_done", 32'(ref_done), 32'd0);
    bm_valid = '0;
    step();
    sys_rst = 1'b0;

    // 1: two READs, tCCD spacing, ptr starts at 0.
    aseed = 2; t = cyc;
    load(0, C_RD); load(3, C_RD);
    exp_push(t + 1, 0, C_RD); exp_push(t + 3, 3, C_RD);
    drain(); idle(6);

    // 2: WRITE then READ separated by tWTR.
    aseed = 3; t = cyc;
    load(1, C_WR); load(2, C_RD);
    exp_push(t + 1, 1, C_WR); exp_push(t + 7, 2, C_RD);
    drain(); idle(6);

    // 3: all banks ACT continuously after reset: every tRRD, order 0..7,0.
    sys_rst = 1'b1; idle(2); sys_rst = 1'b0;
    aseed = 4; t = cyc; hold_vld = 1'b1;
    for (int b = 0; b < NB; b++) load(b, C_ACT);
    for (int k = 0; k < 9; k++) exp_push(t + 4 * k + 1, k % NB, C_ACT);
    while (cyc < t + 34) step();
    bm_valid = '0; hold_vld = 1'b0;
    drain(); idle(6);

    // 5: PRE bypasses a busy tRRD window, pending ACT waits for it.
    aseed = 5; s = cyc;
    load(0, C_ACT); exp_push(s + 1, 0, C_ACT);
    step();
    load(4, C_ACT); load(5, C_PRE);
    exp_push(s + 2, 5, C_PRE); exp_push(s + 5, 4, C_ACT);
    drain(); idle(4);

    // 4: refresh with grants arriving over 10 cycles; PRE held off until done.
    aseed = 6; r = cyc; L = r + 11; exp_done = L + 33; done_seen = 1'b0;
    exp_push(L + 2, 0, C_REF); exp_push(L + 35, 6, C_PRE);
    ref_req = 1'b1;
    chk("rreq_before", 32'(bm_refresh_req), 32'd0);
    while (cyc < L + 40) begin
      step();
      if (cyc == r + 1) begin
        chk("rreq_wait", 32'(bm_refresh_req), 32'd1);
        load(6, C_PRE);
      end
      if (cyc == r + 5) chk("rdy_wait", 32'(bm_ready), 32'd0);
      if (cyc >= r + 2 && cyc < r + 9) bm_refresh_gnt[cyc - r - 2] = 1'b1;
      if (cyc == L) bm_refresh_gnt[7] = 1'b1;
      if (cyc == L + 5) ref_req = 1'b0;
      if (cyc == L + 20) chk("rdy_hold", 32'(bm_ready), 32'd0);
      if (cyc == L + 33) chk("rreq_exit", 32'(bm_refresh_req), 32'd1);
      if (cyc == L + 34) begin
        chk("rreq_run", 32'(bm_refresh_req), 32'd0);
        bm_refresh_gnt = '0;
      end
    end
    chk("ref_done_seen", 32'(done_seen), 32'd1);
    exp_done = -1;
    drain(); idle(4);

    // 6: async reset in REF_HOLD; afterwards RUN with ptr back at 0.
    aseed = 7; q = cyc;
    ref_req = 1'b1; bm_refresh_gnt = '1;
    exp_push(q + 3, 0, C_REF);
    while (cyc < q + 10) step();
    load(6, C_RD); load(7, C_RD);
    chk("hold_rreq", 32'(bm_refresh_req), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_rreq", 32'(bm_refresh_req), 32'd0);
    chk("arst_ready", 32'(bm_ready), 32'd0);
    chk("arst_phy", 32'({phy_valid, phy_a, phy_ba, phy_cas, phy_ras, phy_we}), 32'd0);
    chk("arst_ref_done", 32'(ref_done), 32'd0);
    ref_req = 1'b0; bm_refresh_gnt = '0;
    idle(2);
    sys_rst = 1'b0;
    u = cyc;
    exp_push(u + 1, 6, C_RD); exp_push(u + 3, 7, C_RD);
    drain();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
